// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: the machine-state code of the
// memory stage, the LSU FSM states and the access-size encoding.
package lsu_pkg;

  localparam logic [2:0] MEM_STATU = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // Halves need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(lsu_size_e size, logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane-replicated store data, and
// extraction plus sign/zero extension of load data from the bus word.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic [1:0]  off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // NOTE: every output gets a default before the case, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    be_o      = 4'b1111;
    wdata_o   = wdata_i;
    ld_data_o = rdata_i;
    unique case (size_i)
      SZ_B: begin
        be_o      = 4'b0001 << off_i;
        wdata_o   = {4{wdata_i[7:0]}};
        ld_data_o = ld_unsigned_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        be_o      = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
        ld_data_o = ld_unsigned_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/ack bus transaction per memory instruction during
// the MEM machine state, with misalignment trap and bus timeout.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  statu,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        r8,
  input  logic        r16,
  input  logic        r32,
  input  logic        w8,
  input  logic        w16,
  input  logic        w32,
  input  logic        ld_unsigned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] rd_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        rdy_lsu
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, mis_q, mis_d, err_q, err_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d;
  lsu_size_e   size_q, size_d, size_live, al_size;
  logic        is_store, mem_op, in_mem, start;
  logic [1:0]  al_off;
  logic        al_uns;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_ld;

  // Decode priority when several lines are high: w32>w16>w8>r32>r16>r8.
  always_comb begin
    size_live = SZ_B;
    is_store  = 1'b0;
    if (w32)      begin size_live = SZ_W; is_store = 1'b1; end
    else if (w16) begin size_live = SZ_H; is_store = 1'b1; end
    else if (w8)  begin size_live = SZ_B; is_store = 1'b1; end
    else if (r32) size_live = SZ_W;
    else if (r16) size_live = SZ_H;
  end

  assign mem_op  = r8 | r16 | r32 | w8 | w16 | w32;
  assign in_mem  = (statu == MEM_STATU);
  assign start   = in_mem & mem_op & (state_q == IDLE);
  assign rdy_lsu = (in_mem & ~mem_op) | (state_q == DONE);

  // The aligner sees the live decode while idle and the captured one in REQ.
  assign al_size = (state_q == IDLE) ? size_live : size_q;
  assign al_off  = (state_q == IDLE) ? addr[1:0] : off_q;
  assign al_uns  = (state_q == IDLE) ? ld_unsigned : uns_q;

  lsu_align u_align (
    .size_i        (al_size),
    .off_i         (al_off),
    .ld_unsigned_i (al_uns),
    .wdata_i       (wdata),
    .rdata_i       (mem_rdata),
    .be_o          (al_be),
    .wdata_o       (al_wdata),
    .ld_data_o     (al_ld)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    off_d   = off_q;
    uns_d   = uns_q;
    rd_d    = rd_q;
    mis_d   = mis_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        if (is_misaligned(size_live, addr[1:0])) begin
          state_d = DONE;
          mis_d   = 1'b1;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = al_be;
          wdata_d = al_wdata;
          size_d  = size_live;
          off_d   = addr[1:0];
          uns_d   = ld_unsigned;
          cnt_d   = '0;
        end
      end
      // Once raised, req is held until ack or timeout regardless of statu.
      REQ: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = DONE;
          if (!we_q) rd_d = al_ld;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b1;
          rd_d    = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        mis_d   = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset here is synchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      size_q  <= SZ_B;
      off_q   <= '0;
      uns_q   <= 1'b0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rd_data   = rd_q;
  assign misalign  = mis_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: transaction-level reference model compared on
// every falling edge, directed scenarios with literal expectations, random txns.
module tb_lsu;
  import lsu_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  statu;
  logic [31:0] addr, wdata, mem_rdata;
  logic [5:0]  dec;  // {w32,w16,w8,r32,r16,r8}
  logic        ld_unsigned, mem_ack;
  logic        mem_req, mem_we, misalign, bus_err, rdy_lsu;
  logic [31:0] mem_addr, mem_wdata, rd_data;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .statu(statu), .addr(addr), .wdata(wdata),
    .r8(dec[0]), .r16(dec[1]), .r32(dec[2]), .w8(dec[3]), .w16(dec[4]), .w32(dec[5]),
    .ld_unsigned(ld_unsigned), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .rd_data(rd_data), .misalign(misalign), .bus_err(bus_err), .rdy_lsu(rdy_lsu)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Expected outputs for the current cycle, set by the driver.
  bit          chk_en = 1'b0;
  logic        exp_req, exp_rdy, exp_mis, exp_err, exp_we;
  bit          exp_bus, exp_bus_wd;
  logic [31:0] exp_rd = '0, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  int          cur_k;
  // Observations used by the literal checks.
  int          obs_req_cycles, rdy_k;
  logic        obs_mis, obs_err, obs_we;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata;

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", mem_req, exp_req);
      check("rdy_lsu", rdy_lsu, exp_rdy);
      check("misalign", misalign, exp_mis);
      check("bus_err", bus_err, exp_err);
      check("rd_data", rd_data, exp_rd);
      if (exp_bus) begin
        check("mem_addr", mem_addr, exp_addr);
        check("mem_be", mem_be, exp_be);
        check("mem_we", mem_we, exp_we);
      end
      if (exp_bus_wd) check("mem_wdata", mem_wdata, exp_wdata);
      if (mem_req) begin
        obs_req_cycles++;
        obs_be = mem_be; obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we;
      end
      if (rdy_lsu && rdy_k < 0) rdy_k = cur_k;
      if (misalign) obs_mis = 1'b1;
      if (bus_err) obs_err = 1'b1;
    end
  end

  // Reference model: plain arithmetic over the access rules.
  function automatic int ref_size(input logic [5:0] d);
    if (d[5]) return 4;
    if (d[4]) return 2;
    if (d[3]) return 1;
    if (d[2]) return 4;
    if (d[1]) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] ref_be(input int sz, input int off);
    if (sz == 1) return 4'(1 << off);
    if (sz == 2) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] wd);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input int sz, input int off, input logic [31:0] rd, input logic uns);
    longint v, lim;
    if (sz == 4) return rd;
    lim = (sz == 1) ? 256 : 65536;
    v = longint'(rd >> (8 * off)) % lim;
    if (!uns && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_exp();
    exp_req = 1'b0; exp_rdy = 1'b0; exp_mis = 1'b0; exp_err = 1'b0;
    exp_bus = 1'b0; exp_bus_wd = 1'b0;
  endtask

  // ack_at: REQ cycle (1-based) carrying mem_ack; 0 means never.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input logic [5:0] d, input logic uns, input int ack_at, input bit wander);
    int sz, off, n;
    bit st, mis, tmo;
    sz  = ref_size(d);
    off = int'(a[1:0]);
    st  = |d[5:3];
    mis = (off % sz) != 0;
    tmo = (ack_at == 0) || (ack_at > T);
    n   = tmo ? T : ack_at;
    step();
    statu = MEM_STATU; addr = a; wdata = wd; dec = d; ld_unsigned = uns;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    obs_req_cycles = 0; rdy_k = -1; obs_mis = 1'b0; obs_err = 1'b0; cur_k = 0;
    idle_exp();
    if (!mis) begin
      for (int k = 1; k <= n; k++) begin
        step();
        cur_k = k;
        mem_ack = (k == ack_at);
        mem_rdata = (k == ack_at) ? rdat : $urandom;
        statu = wander ? 3'($urandom_range(3, 7)) : MEM_STATU;
        exp_req = 1'b1; exp_bus = 1'b1; exp_bus_wd = st;
        exp_addr = a & 32'hFFFF_FFFC; exp_be = ref_be(sz, off); exp_we = st;
        exp_wdata = ref_wdata(sz, wd);
      end
    end
    step();
    cur_k = mis ? 1 : n + 1;
    statu = MEM_STATU; mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    idle_exp();
    exp_rdy = 1'b1; exp_mis = mis; exp_err = !mis && tmo;
    if (!mis) begin
      if (tmo) exp_rd = '0;
      else if (!st) exp_rd = ref_load(sz, off, rdat, uns);
    end
    step();
    cur_k++;
    statu = 3'b000; dec = '0; mem_ack = 1'($urandom_range(0, 1));
    idle_exp();
  endtask

  initial begin
    rst = 1'b1; statu = '0; addr = '0; wdata = '0; dec = '0;
    ld_unsigned = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    cur_k = 0; rdy_k = -1; obs_req_cycles = 0;
    idle_exp();
    exp_bus = 1'b1; exp_bus_wd = 1'b1; exp_addr = '0; exp_be = '0; exp_we = 1'b0; exp_wdata = '0;
    step(); step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    // lbu / lb at 0x1003, ack on the 4th REQ cycle.
    run_txn(32'h1003, 32'h0, 32'h80FF_FF12, 6'b000001, 1'b1, 4, 1'b0);
    check("lbu_rd", rd_data, 32'h0000_0080);
    check("lbu_be", obs_be, 4'b1000);
    check("lbu_addr", obs_addr, 32'h1000);
    check("lbu_lat", rdy_k, 5);
    run_txn(32'h1003, 32'h0, 32'h80FF_FF12, 6'b000001, 1'b0, 4, 1'b0);
    check("lb_rd", rd_data, 32'hFFFF_FF80);

    // sh at 0x2002, immediate ack.
    run_txn(32'h2002, 32'h1234_ABCD, 32'h0, 6'b010000, 1'b0, 1, 1'b0);
    check("sh_we", obs_we, 1'b1);
    check("sh_be", obs_be, 4'b1100);
    check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    check("sh_lat", rdy_k, 2);

    // Misaligned lw: no bus cycle, load result untouched.
    run_txn(32'h3001, 32'h0, 32'h0, 6'b000100, 1'b0, 1, 1'b0);
    check("mis_req_cycles", obs_req_cycles, 0);
    check("mis_flag", obs_mis, 1'b1);
    check("mis_lat", rdy_k, 1);
    check("mis_rd", rd_data, 32'hFFFF_FF80);

    // Timeout lw at 0x4000, statu wandering off MEM meanwhile.
    run_txn(32'h4000, 32'h0, 32'h0, 6'b000100, 1'b0, 0, 1'b1);
    check("tmo_req_cycles", obs_req_cycles, T);
    check("tmo_err", obs_err, 1'b1);
    check("tmo_lat", rdy_k, T + 1);
    check("tmo_rd", rd_data, 32'h0);

    // Non-memory instruction in MEM: combinational ready, no request.
    step();
    statu = MEM_STATU; dec = '0; mem_ack = 1'b1;
    idle_exp(); exp_rdy = 1'b1;
    step();
    statu = 3'b000; mem_ack = 1'b0;
    idle_exp();

    // Reset while in REQ, then a normal sw.
    step();
    statu = MEM_STATU; addr = 32'h5000; dec = 6'b000100; mem_ack = 1'b0;
    idle_exp();
    for (int k = 1; k <= 2; k++) begin
      step();
      if (k == 2) rst = 1'b1;
      exp_req = 1'b1; exp_bus = 1'b1; exp_addr = 32'h5000; exp_be = 4'hF; exp_we = 1'b0;
    end
    step();
    rst = 1'b0; statu = 3'b000; dec = '0;
    idle_exp();
    exp_rd = '0; exp_bus = 1'b1; exp_bus_wd = 1'b1;
    exp_addr = '0; exp_be = '0; exp_we = 1'b0; exp_wdata = '0;
    run_txn(32'h6000, 32'hDEAD_BEEF, 32'h0, 6'b100000, 1'b0, 2, 1'b0);
    check("sw_be", obs_be, 4'hF);
    check("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
    check("sw_lat", rdy_k, 3);

    // Random transactions, including multi-line decodes and timeouts.
    for (int i = 0; i < 300; i++) begin
      logic [5:0] d;
      if ($urandom_range(0, 3) == 0) d = 6'($urandom_range(1, 63));
      else d = 6'(1 << $urandom_range(0, 5));
      run_txn($urandom, $urandom, $urandom, d, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
